// File: rtl/mac_block_accum.sv
// Block accumulator behind the multiply-add pipeline: sums N consecutive MAC results
// and reports the block peak, handing each completed block downstream over valid/ready.
module mac_block_accum #(
    parameter int unsigned PAR = 3,
    parameter int unsigned N   = 4,
    localparam int unsigned DW = 2 * PAR + 2,
    localparam int unsigned SW = DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          clear,
    output logic [SW-1:0] sum,
    output logic [DW-1:0] peak,
    output logic          sum_valid,
    input  logic          sum_ready
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    typedef enum logic {
        StAcc,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] max_q, max_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [DW-1:0] peak_q, peak_d;
    logic          sum_valid_q, sum_valid_d;

    logic [SW-1:0] acc_next;
    logic [DW-1:0] max_next;
    logic          accept;

    // SW carries enough headroom that N full-scale samples never wrap.
    assign acc_next  = acc_q + SW'(din);
    assign max_next  = (din > max_q) ? din : max_q;
    assign din_ready = (state_q == StAcc) && !clear;
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        sum_d       = sum_q;
        peak_d      = peak_q;
        sum_valid_d = sum_valid_q;

        unique case (state_q)
            StAcc: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    max_d = '0;
                end else if (accept) begin
                    if (cnt_q == LastIdx) begin
                        sum_d       = acc_next;
                        peak_d      = max_next;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        max_d       = '0;
                        state_d     = StHold;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + 1'b1;
                        max_d = max_next;
                    end
                end
            end
            StHold: begin
                // clear is deliberately ignored here; the held block is still delivered.
                if (sum_valid_q && sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            peak_q      <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            peak_q      <= peak_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum       = sum_q;
    assign peak      = peak_q;
    assign sum_valid = sum_valid_q;

endmodule
